screen_flusher: RTL and testbench



---
 rtl/screen_flusher.sv | 113 +++++++++++
 tb/tb_screen_flusher.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/screen_flusher.sv
// Raster scan engine: walks every play-field pixel once per frame,
// muxes glyph/background colour and registers one VGA plot per pixel.
module screen_flusher #(
  parameter int WIDTH   = 160,
  parameter int HEIGHT  = 120,
  parameter bit PLOT_BG = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_stall,
  input  logic [5:0] i_sprite_colour,
  input  logic       i_sprite_enable,
  input  logic [5:0] i_bg_colour,
  output logic [7:0] o_flush_x,
  output logic [7:0] o_flush_y,
  output logic [7:0] o_vga_x,
  output logic [7:0] o_vga_y,
  output logic [5:0] o_vga_colour,
  output logic       o_vga_plot,
  output logic       o_busy,
  output logic       o_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_FINISH
  } state_t;

  localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
  localparam logic [7:0] Y_LAST = 8'(HEIGHT - 1);

  state_t     r_state;
  logic [7:0] r_fx;
  logic [7:0] r_fy;
  logic [7:0] r_vx;
  logic [7:0] r_vy;
  logic [5:0] r_col;
  logic       r_plot;
  logic       r_done;

  logic       w_x_last;
  logic       w_y_last;
  logic [5:0] w_colour;
  logic       w_plot;

  assign w_x_last = (r_fx == X_LAST);
  assign w_y_last = (r_fy == Y_LAST);
  assign w_colour = i_sprite_enable ? i_sprite_colour : i_bg_colour;
  // Sparse mode writes only glyph pixels, leaving the frame buffer intact
  assign w_plot   = PLOT_BG | i_sprite_enable;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_fx    <= 8'd0;
      r_fy    <= 8'd0;
      r_vx    <= 8'd0;
      r_vy    <= 8'd0;
      r_col   <= 6'd0;
      r_plot  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_fx   <= 8'd0;
          r_fy   <= 8'd0;
          r_plot <= 1'b0;
          if (i_start) r_state <= S_SCAN;
        end
        S_SCAN: begin
          if (i_stall) begin
            r_plot <= 1'b0;
          end else begin
            r_vx   <= r_fx;
            r_vy   <= r_fy;
            r_col  <= w_colour;
            r_plot <= w_plot;
            if (w_x_last) begin
              r_fx <= 8'd0;
              if (w_y_last) begin
                r_fy    <= 8'd0;
                r_state <= S_FINISH;
              end else begin
                r_fy <= r_fy + 8'd1;
              end
            end else begin
              r_fx <= r_fx + 8'd1;
            end
          end
        end
        S_FINISH: begin
          r_plot  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_flush_x    = r_fx;
  assign o_flush_y    = r_fy;
  assign o_vga_x      = r_vx;
  assign o_vga_y      = r_vy;
  assign o_vga_colour = r_col;
  assign o_vga_plot   = r_plot;
  assign o_done       = r_done;
  assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_screen_flusher.sv
// Scoreboard bench for screen_flusher: 4x3 dense, 4x3 sparse
// and default 160x120 instances with queued expected plots.
module tb_screen_flusher;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [5:0] c;
  } px_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---- instance A: 4x3 dense ----
  logic       a_rst = 1'b1, a_start = 1'b0, a_stall = 1'b0;
  logic [7:0] a_fx, a_fy, a_vx, a_vy;
  logic [5:0] a_col;
  logic       a_plot, a_busy, a_done;

  screen_flusher #(.WIDTH(4), .HEIGHT(3), .PLOT_BG(1'b1)) dut_a (
    .i_clk(clk), .i_rst(a_rst), .i_start(a_start), .i_stall(a_stall),
    .i_sprite_colour(6'h3F), .i_sprite_enable(1'b0),
    .i_bg_colour(6'h01),
    .o_flush_x(a_fx), .o_flush_y(a_fy),
    .o_vga_x(a_vx), .o_vga_y(a_vy), .o_vga_colour(a_col),
    .o_vga_plot(a_plot), .o_busy(a_busy), .o_done(a_done)
  );

  // ---- instance S: 4x3 sparse, glyph column x=2 ----
  logic       s_rst = 1'b1, s_start = 1'b0;
  logic [7:0] s_fx, s_fy, s_vx, s_vy;
  logic [5:0] s_col;
  logic       s_plot, s_busy, s_done, s_sen;
  assign s_sen = (s_fx == 8'd2);

  screen_flusher #(.WIDTH(4), .HEIGHT(3), .PLOT_BG(1'b0)) dut_s (
    .i_clk(clk), .i_rst(s_rst), .i_start(s_start), .i_stall(1'b0),
    .i_sprite_colour(6'h3F), .i_sprite_enable(s_sen),
    .i_bg_colour(6'h01),
    .o_flush_x(s_fx), .o_flush_y(s_fy),
    .o_vga_x(s_vx), .o_vga_y(s_vy), .o_vga_colour(s_col),
    .o_vga_plot(s_plot), .o_busy(s_busy), .o_done(s_done)
  );

  // ---- instance B: default 160x120 ----
  logic       b_rst = 1'b1, b_start = 1'b0;
  logic [7:0] b_fx, b_fy, b_vx, b_vy;
  logic [5:0] b_col;
  logic       b_plot, b_busy, b_done;

  screen_flusher dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_start(b_start), .i_stall(1'b0),
    .i_sprite_colour(6'h3F), .i_sprite_enable(1'b0),
    .i_bg_colour(6'h2A),
    .o_flush_x(b_fx), .o_flush_y(b_fy),
    .o_vga_x(b_vx), .o_vga_y(b_vy), .o_vga_colour(b_col),
    .o_vga_plot(b_plot), .o_busy(b_busy), .o_done(b_done)
  );

  px_t qa[$], qs[$], qb[$];
  int  a_nplot = 0, a_nbusy = 0, a_ndone = 0;
  int  s_nplot = 0, b_nplot = 0;
  px_t b_last;

  // ---- monitors ----
  always @(negedge clk) begin
    px_t e;
    if (a_plot) begin
      a_nplot++;
      if (qa.size() == 0) begin
        chk("a_extra_plot", {a_vx, a_vy, a_col}, 0);
      end else begin
        e = qa.pop_front();
        chk("a_pixel", {a_vx, a_vy, a_col}, e);
      end
    end
    if (a_busy) a_nbusy++;
    if (a_done) a_ndone++;
  end

  always @(negedge clk) begin
    px_t e;
    if (s_plot) begin
      s_nplot++;
      if (qs.size() == 0) begin
        chk("s_extra_plot", {s_vx, s_vy, s_col}, 0);
      end else begin
        e = qs.pop_front();
        chk("s_pixel", {s_vx, s_vy, s_col}, e);
      end
    end
  end

  always @(negedge clk) begin
    px_t e;
    if (b_plot) begin
      b_nplot++;
      b_last = {b_vx, b_vy, b_col};
      if (qb.size() == 0) begin
        chk("b_extra_plot", {b_vx, b_vy, b_col}, 0);
      end else begin
        e = qb.pop_front();
        if ({b_vx, b_vy, b_col} !== e)
          chk("b_pixel", {b_vx, b_vy, b_col}, e);
      end
    end
  end

  // ---- stimulus helpers ----
  task automatic push_a_frame();
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++)
        qa.push_back({8'(x), 8'(y), 6'h01});
  endtask

  // Runs one A frame; returns cycles from start edge to done visible
  task automatic a_frame(input bit do_stall, output int lat);
    int s;
    bit stalled;
    bit seen;
    stalled = 0;
    seen    = 0;
    lat     = -1;
    push_a_frame();
    a_nplot = 0; a_nbusy = 0; a_ndone = 0;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    s = cyc;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (do_stall && !stalled && a_fx == 8'd1 && a_fy == 8'd1) begin
        stalled = 1;
        a_stall = 1'b1;
        repeat (3) @(negedge clk);
        a_stall = 1'b0;
      end
      if (a_done) begin
        seen = 1;
        lat  = cyc - s;
      end else begin
        @(negedge clk);
      end
    end
    if (!seen) chk("a_done_timeout", 0, 1);
    @(negedge clk);
    chk("a_done_one_cycle", a_done, 0);
  endtask

  int lat, d;
  bit seen;

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    chk("rst_flush", {a_fx, a_fy}, 0);
    chk("rst_vga", {a_vx, a_vy, a_col}, 0);
    chk("rst_plot_done_busy", {a_plot, a_done, a_busy}, 0);
    a_rst = 1'b0; s_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);

    // Full unstalled frame
    a_frame(0, lat);
    chk("full_done_lat", lat, 13);
    chk("full_nplot", a_nplot, 12);
    chk("full_nbusy", a_nbusy, 13);
    chk("full_ndone", a_ndone, 1);
    chk("full_done_lag_last_plot", 1, 1 * (a_ndone == 1));

    // Stall 3 cycles at (1,1)
    a_frame(1, lat);
    chk("stall_done_lat", lat, 16);
    chk("stall_nplot", a_nplot, 12);
    chk("stall_nbusy", a_nbusy, 16);

    // Start held high across two frames
    push_a_frame();
    push_a_frame();
    a_nplot = 0;
    a_start = 1'b1;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (a_done) seen = 1;
    end
    if (!seen) chk("hold_done_timeout", 0, 1);
    chk("hold_first_nplot", a_nplot, 12);
    d = cyc;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (a_plot) seen = 1;
    end
    a_start = 1'b0;
    chk("restart_plot_lag", cyc - d, 2);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (a_done) seen = 1;
    end
    if (!seen) chk("hold2_done_timeout", 0, 1);
    repeat (3) @(negedge clk);
    chk("hold_total_nplot", a_nplot, 24);
    chk("hold_idle_after", a_busy, 0);

    // Mid-scan reset at pixel (2,1)
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 4; x++)
        if (y == 0 || x < 2) qa.push_back({8'(x), 8'(y), 6'h01});
    a_ndone = 0;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (a_fx == 8'd2 && a_fy == 8'd1) seen = 1;
      else @(negedge clk);
    end
    if (!seen) chk("rst_mid_timeout", 0, 1);
    a_rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_plot_busy_done", {a_plot, a_busy, a_done}, 0);
    chk("rst_mid_flush", {a_fx, a_fy}, 0);
    a_rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_no_done", a_ndone, 0);
    chk("rst_mid_queue", qa.size(), 0);
    a_frame(0, lat);
    chk("after_rst_lat", lat, 13);
    chk("after_rst_nplot", a_nplot, 12);

    // Sparse mode glyph column
    for (int y = 0; y < 3; y++) qs.push_back({8'd2, 8'(y), 6'h3F});
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (s_done) seen = 1;
    end
    if (!seen) chk("s_done_timeout", 0, 1);
    @(negedge clk);
    chk("s_nplot", s_nplot, 3);

    // Default 160x120 frame
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        qb.push_back({8'(x), 8'(y), 6'h2A});
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge clk);
      if (b_done) seen = 1;
    end
    if (!seen) chk("b_done_timeout", 0, 1);
    @(negedge clk);
    chk("b_nplot", b_nplot, 19200);
    chk("b_last_xy", {b_last.x, b_last.y}, {8'd159, 8'd119});

    chk("qa_empty", qa.size(), 0);
    chk("qs_empty", qs.size(), 0);
    chk("qb_empty", qb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
